readonly_cache_nway: RTL and testbench

READONLY_CACHE_NWAY -- requirements
Module: readonly_cache_nway

---
 rtl/readonly_cache_nway.sv | 214 +++++++++++++++++++++
 tb/tb_readonly_cache_nway.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/readonly_cache_nway.sv
// Read-only N-way set-associative cache with an AXI4 read-burst line fill.
// Lookups are combinational; a miss captures its line and refills one victim
// way per burst. Replacement picks an invalid way first, then the oldest way.
module readonly_cache_nway #(
  parameter int C_DATA_WIDTH              = 32,
  parameter int C_ADDRESS_WIDTH           = 32,
  parameter int C_CACHE_SET_CNT           = 4,
  parameter int C_CACHE_WAY_CNT           = 4,
  parameter int C_CACHE_LINE_WIDTH        = 128,
  parameter int C_CACHE_LRU_COUNTER_WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RES,
  input  logic [C_ADDRESS_WIDTH-1:0] S_RADDR,
  input  logic                       S_ARVALID,
  output logic [C_DATA_WIDTH-1:0]    S_RDATA,
  output logic                       S_RVALID,
  input  logic                       S_FLUSH,
  output logic                       S_BUSY,
  output logic                       S_RERR,
  output logic [C_ADDRESS_WIDTH-1:0] M_ARADDR,
  output logic [7:0]                 M_ARLEN,
  output logic                       M_ARVALID,
  input  logic                       M_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]    M_RDATA,
  input  logic [1:0]                 M_RRESP,
  input  logic                       M_RVALID,
  input  logic                       M_RLAST,
  output logic                       M_RREADY
);

  localparam int WORDS  = C_CACHE_LINE_WIDTH / C_DATA_WIDTH;
  localparam int OFF_W  = $clog2(C_DATA_WIDTH / 8);
  localparam int BLK_W  = $clog2(WORDS);
  localparam int SET_W  = $clog2(C_CACHE_SET_CNT);
  localparam int WAY_W  = $clog2(C_CACHE_WAY_CNT);
  localparam int TAG_W  = C_ADDRESS_WIDTH - OFF_W - BLK_W - SET_W;
  localparam int BLK_IW = (BLK_W > 0) ? BLK_W : 1;
  localparam int SET_IW = (SET_W > 0) ? SET_W : 1;
  localparam int WAY_IW = (WAY_W > 0) ? WAY_W : 1;
  localparam int BEAT_W = BLK_W + 1;
  localparam int AGE_W  = C_CACHE_LRU_COUNTER_WIDTH;

  localparam logic [C_ADDRESS_WIDTH-1:0] BLK_MASK  = C_ADDRESS_WIDTH'(WORDS - 1);
  localparam logic [C_ADDRESS_WIDTH-1:0] SET_MASK  = C_ADDRESS_WIDTH'(C_CACHE_SET_CNT - 1);
  localparam logic [C_ADDRESS_WIDTH-1:0] LINE_MASK = C_ADDRESS_WIDTH'((C_CACHE_LINE_WIDTH / 8) - 1);
  localparam logic [BEAT_W-1:0]          LAST_BEAT = BEAT_W'(WORDS - 1);
  localparam logic [BEAT_W-1:0]          BEAT_END  = BEAT_W'(WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_FILL} state_t;

  state_t state_q, state_d;

  logic [C_DATA_WIDTH-1:0]    data_mem [C_CACHE_SET_CNT][C_CACHE_WAY_CNT][WORDS];
  logic [TAG_W-1:0]           tag_mem  [C_CACHE_SET_CNT][C_CACHE_WAY_CNT];
  logic [C_CACHE_WAY_CNT-1:0] valid_q  [C_CACHE_SET_CNT];
  logic [AGE_W-1:0]           age_q    [C_CACHE_SET_CNT][C_CACHE_WAY_CNT];

  logic [SET_IW-1:0] req_set, cap_set_q;
  logic [BLK_IW-1:0] req_blk;
  logic [TAG_W-1:0]  req_tag, cap_tag_q;
  logic [WAY_IW-1:0] hit_way, victim, cap_way_q;
  logic [AGE_W-1:0]  oldest;
  logic [BEAT_W-1:0] beat_q;
  logic [C_ADDRESS_WIDTH-1:0] ar_addr_q;
  logic hit, inv_found, err_q, flush_pend_q;
  logic miss_start, beat_fire, beat_bad, term, fill_fail, fill_ok, apply_flush;

  // Split the request address into word, set and tag fields.
  assign req_blk = BLK_IW'((S_RADDR >> OFF_W) & BLK_MASK);
  assign req_set = SET_IW'((S_RADDR >> (OFF_W + BLK_W)) & SET_MASK);
  assign req_tag = TAG_W'(S_RADDR >> (OFF_W + BLK_W + SET_W));

  // Tag compare across the addressed set; lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = C_CACHE_WAY_CNT - 1; w >= 0; w--) begin
      if (valid_q[req_set][w] && (tag_mem[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_IW'(w);
      end
    end
  end

  assign S_RVALID = S_ARVALID & hit;
  assign S_RDATA  = data_mem[req_set][hit_way][req_blk];

  // Victim choice: first invalid way, otherwise the oldest (ties to lowest).
  always_comb begin
    victim    = '0;
    inv_found = 1'b0;
    oldest    = age_q[req_set][0];
    for (int w = 0; w < C_CACHE_WAY_CNT; w++) begin
      if (!inv_found && !valid_q[req_set][w]) begin
        victim    = WAY_IW'(w);
        inv_found = 1'b1;
      end
    end
    if (!inv_found) begin
      for (int w = 1; w < C_CACHE_WAY_CNT; w++) begin
        if (age_q[req_set][w] > oldest) begin
          oldest = age_q[req_set][w];
          victim = WAY_IW'(w);
        end
      end
    end
  end

  // A burst is good only if every beat is OKAY and RLAST lands on the final word.
  assign miss_start  = (state_q == ST_IDLE) & S_ARVALID & ~hit & ~S_FLUSH;
  assign beat_fire   = (state_q == ST_FILL) & M_RVALID;
  assign beat_bad    = (M_RRESP != 2'b00) | (M_RLAST != (beat_q == LAST_BEAT)) | (beat_q >= BEAT_END);
  assign term        = beat_fire & M_RLAST;
  assign fill_fail   = err_q | beat_bad;
  assign fill_ok     = term & ~fill_fail & ~flush_pend_q & ~S_FLUSH;
  assign apply_flush = ((state_q == ST_IDLE) & S_FLUSH) | (term & (flush_pend_q | S_FLUSH));

  assign S_RERR   = term & fill_fail;
  assign S_BUSY   = (state_q != ST_IDLE) | flush_pend_q;
  assign M_ARADDR = ar_addr_q;

  // State register.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one miss in flight at a time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (miss_start) state_d = ST_ADDR;
      ST_ADDR: if (M_ARREADY)  state_d = ST_FILL;
      ST_FILL: if (term)       state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // AXI handshake outputs decoded from state.
  always_comb begin
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    M_ARLEN   = '0;
    case (state_q)
      ST_ADDR: begin
        M_ARVALID = 1'b1;
        M_ARLEN   = 8'(WORDS - 1);
      end
      ST_FILL: M_RREADY = 1'b1;
      default: ;
    endcase
  end

  // Miss bookkeeping: captured line/set/way, beat count, error and flush flags.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      ar_addr_q    <= '0;
      cap_set_q    <= '0;
      cap_way_q    <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      if (miss_start) begin
        ar_addr_q <= S_RADDR & ~LINE_MASK;
        cap_set_q <= req_set;
        cap_way_q <= victim;
      end
      if ((state_q == ST_ADDR) && M_ARREADY) begin
        beat_q <= '0;
        err_q  <= 1'b0;
      end else if (beat_fire) begin
        if (beat_q != BEAT_END) beat_q <= beat_q + 1'b1;
        err_q <= err_q | beat_bad;
      end
      if (term)                                     flush_pend_q <= 1'b0;
      else if ((state_q != ST_IDLE) && S_FLUSH)     flush_pend_q <= 1'b1;
    end
  end

  // Valid bits and age counters; the victim goes invalid while it is refilled.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      for (int s = 0; s < C_CACHE_SET_CNT; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < C_CACHE_WAY_CNT; w++) age_q[s][w] <= '0;
      end
    end else begin
      if (apply_flush) begin
        for (int s = 0; s < C_CACHE_SET_CNT; s++) valid_q[s] <= '0;
      end else begin
        if (miss_start) valid_q[req_set][victim]    <= 1'b0;
        if (fill_ok)    valid_q[cap_set_q][cap_way_q] <= 1'b1;
      end
      if (S_RVALID) begin
        for (int w = 0; w < C_CACHE_WAY_CNT; w++) begin
          if (WAY_IW'(w) == hit_way)   age_q[req_set][w] <= '0;
          else if (age_q[req_set][w] != '1) age_q[req_set][w] <= age_q[req_set][w] + 1'b1;
        end
      end
      if (fill_ok) age_q[cap_set_q][cap_way_q] <= '0;
    end
  end

  // Line data and tags; beats past the line end are dropped.
  always_ff @(posedge CLK) begin
    if (miss_start) cap_tag_q <= req_tag;
    if (beat_fire && (beat_q < BEAT_END))
      data_mem[cap_set_q][cap_way_q][BLK_IW'(beat_q)] <= M_RDATA;
    if (fill_ok) tag_mem[cap_set_q][cap_way_q] <= cap_tag_q;
  end

endmodule

// File: tb/tb_readonly_cache_nway.sv
// Directed bench for readonly_cache_nway: cold miss, eviction, fill errors,
// flush during a fill, request changes while waiting, and reset mid-burst.
module tb_readonly_cache_nway;

  logic        CLK = 1'b0;
  logic        RES;
  logic [31:0] S_RADDR;
  logic        S_ARVALID, S_FLUSH, M_ARREADY, M_RVALID, M_RLAST;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;

  logic [31:0] S_RDATA, M_ARADDR;
  logic        S_RVALID, S_BUSY, S_RERR, M_ARVALID, M_RREADY;
  logic [7:0]  M_ARLEN;

  logic [31:0] w1_rdata, w1_araddr, w8_rdata, w8_araddr;
  logic        w1_rvalid, w1_busy, w1_rerr, w1_arvalid, w1_rready;
  logic        w8_rvalid, w8_busy, w8_rerr, w8_arvalid, w8_rready;
  logic [7:0]  w1_arlen, w8_arlen;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  readonly_cache_nway dut (
    .CLK(CLK), .RES(RES), .S_RADDR(S_RADDR), .S_ARVALID(S_ARVALID),
    .S_RDATA(S_RDATA), .S_RVALID(S_RVALID), .S_FLUSH(S_FLUSH), .S_BUSY(S_BUSY),
    .S_RERR(S_RERR), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARVALID(M_ARVALID),
    .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID),
    .M_RLAST(M_RLAST), .M_RREADY(M_RREADY)
  );

  readonly_cache_nway #(.C_CACHE_WAY_CNT(1)) dut_w1 (
    .CLK(CLK), .RES(RES), .S_RADDR(S_RADDR), .S_ARVALID(S_ARVALID),
    .S_RDATA(w1_rdata), .S_RVALID(w1_rvalid), .S_FLUSH(S_FLUSH), .S_BUSY(w1_busy),
    .S_RERR(w1_rerr), .M_ARADDR(w1_araddr), .M_ARLEN(w1_arlen), .M_ARVALID(w1_arvalid),
    .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID),
    .M_RLAST(M_RLAST), .M_RREADY(w1_rready)
  );

  readonly_cache_nway #(.C_CACHE_WAY_CNT(8)) dut_w8 (
    .CLK(CLK), .RES(RES), .S_RADDR(S_RADDR), .S_ARVALID(S_ARVALID),
    .S_RDATA(w8_rdata), .S_RVALID(w8_rvalid), .S_FLUSH(S_FLUSH), .S_BUSY(w8_busy),
    .S_RERR(w8_rerr), .M_ARADDR(w8_araddr), .M_ARLEN(w8_arlen), .M_ARVALID(w8_arvalid),
    .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID),
    .M_RLAST(M_RLAST), .M_RREADY(w8_rready)
  );

  task automatic clear_inputs();
    S_RADDR = '0; S_ARVALID = 1'b0; S_FLUSH = 1'b0; M_ARREADY = 1'b0;
    M_RVALID = 1'b0; M_RLAST = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge CLK); RES = 1'b1; clear_inputs();
    @(negedge CLK); RES = 1'b0;
  endtask

  // Present a missing address for one cycle and expect the AR request next.
  task automatic start_miss(input logic [31:0] addr, input string tag);
    @(negedge CLK); S_RADDR = addr; S_ARVALID = 1'b1; #1;
    checks++; if (S_RVALID !== 1'b0) begin errors++; $display("FAIL %s_miss: S_RVALID got %b expected 0", tag, S_RVALID); end
    @(negedge CLK); S_ARVALID = 1'b0; #1;
    checks++; if (M_ARVALID !== 1'b1) begin errors++; $display("FAIL %s_arvalid: got %b expected 1", tag, M_ARVALID); end
    checks++; if (M_ARADDR !== (addr & 32'hFFFF_FFF0)) begin errors++; $display("FAIL %s_araddr: got %h expected %h", tag, M_ARADDR, addr & 32'hFFFF_FFF0); end
    checks++; if (M_ARLEN !== 8'd3) begin errors++; $display("FAIL %s_arlen: got %0d expected 3", tag, M_ARLEN); end
  endtask

  task automatic accept_ar(input string tag);
    M_ARREADY = 1'b1;
    @(negedge CLK); M_ARREADY = 1'b0; #1;
    checks++; if ({M_ARVALID, M_RREADY} !== 2'b01) begin errors++; $display("FAIL %s_fill_entry: arvalid,rready got %b expected 01", tag, {M_ARVALID, M_RREADY}); end
  endtask

  // Drive beats 0..last_beat; RERR is expected only on the final beat when exp_err.
  task automatic serve(input logic [31:0] d0, input int err_beat, input int last_beat,
                       input int flush_beat, input logic exp_err, input string tag);
    for (int b = 0; b <= last_beat; b++) begin
      M_RVALID = 1'b1; M_RDATA = d0 + 32'(b);
      M_RRESP = (b == err_beat) ? 2'd2 : 2'd0;
      M_RLAST = (b == last_beat); S_FLUSH = (b == flush_beat); #1;
      checks++; if (S_RERR !== ((b == last_beat) && exp_err)) begin errors++; $display("FAIL %s_rerr_beat%0d: got %b expected %b", tag, b, S_RERR, (b == last_beat) && exp_err); end
      if (flush_beat >= 0) begin
        checks++; if (S_BUSY !== 1'b1) begin errors++; $display("FAIL %s_busy_beat%0d: got %b expected 1", tag, b, S_BUSY); end
      end
      @(negedge CLK);
    end
    M_RVALID = 1'b0; M_RLAST = 1'b0; M_RRESP = 2'b00; S_FLUSH = 1'b0; #1;
    checks++; if ({S_RERR, M_RREADY, S_BUSY} !== 3'b000) begin errors++; $display("FAIL %s_after_fill: rerr,rready,busy got %b expected 000", tag, {S_RERR, M_RREADY, S_BUSY}); end
  endtask

  task automatic fill_line(input logic [31:0] addr, input logic [31:0] d0, input string tag);
    start_miss(addr, tag);
    accept_ar(tag);
    serve(d0, -1, 3, -1, 1'b0, tag);
  endtask

  task automatic probe_hit(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    @(negedge CLK); S_RADDR = addr; S_ARVALID = 1'b1; #1;
    checks++; if (S_RVALID !== 1'b1) begin errors++; $display("FAIL %s_hit: S_RVALID got %b expected 1", tag, S_RVALID); end
    checks++; if (S_RDATA !== exp) begin errors++; $display("FAIL %s_data: got %h expected %h", tag, S_RDATA, exp); end
    @(negedge CLK); S_ARVALID = 1'b0;
  endtask

  // Miss probe with flush raised too, so no fill is launched.
  task automatic probe_miss(input logic [31:0] addr, input string tag);
    @(negedge CLK); S_RADDR = addr; S_ARVALID = 1'b1; S_FLUSH = 1'b1; #1;
    checks++; if (S_RVALID !== 1'b0) begin errors++; $display("FAIL %s_nohit: S_RVALID got %b expected 0", tag, S_RVALID); end
    @(negedge CLK); S_ARVALID = 1'b0; S_FLUSH = 1'b0; #1;
    checks++; if ({M_ARVALID, S_BUSY} !== 2'b00) begin errors++; $display("FAIL %s_no_fill: arvalid,busy got %b expected 00", tag, {M_ARVALID, S_BUSY}); end
  endtask

  task automatic test_reset();
    RES = 1'b1; clear_inputs(); S_RADDR = 32'h0000_1004; S_ARVALID = 1'b1; #1;
    checks++; if ({M_ARVALID, M_RREADY, S_RERR, S_BUSY, S_RVALID} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {M_ARVALID, M_RREADY, S_RERR, S_BUSY, S_RVALID}); end
    checks++; if (M_ARADDR !== 32'h0) begin errors++; $display("FAIL reset_araddr: got %h expected 0", M_ARADDR); end
    checks++; if (M_ARLEN !== 8'h0) begin errors++; $display("FAIL reset_arlen: got %h expected 0", M_ARLEN); end
    @(negedge CLK); S_ARVALID = 1'b0;
    @(negedge CLK); RES = 1'b0;
  endtask

  task automatic test_cold_miss();
    do_reset();
    start_miss(32'h0000_1004, "cold");
    checks++; if ({w1_arvalid, w8_arvalid} !== 2'b11) begin errors++; $display("FAIL cold_arvalid_w1w8: got %b expected 11", {w1_arvalid, w8_arvalid}); end
    checks++; if (w1_araddr !== 32'h0000_1000) begin errors++; $display("FAIL cold_araddr_w1: got %h expected 00001000", w1_araddr); end
    checks++; if (w8_araddr !== 32'h0000_1000) begin errors++; $display("FAIL cold_araddr_w8: got %h expected 00001000", w8_araddr); end
    accept_ar("cold");
    serve(32'hA0, -1, 3, -1, 1'b0, "cold");
    S_RADDR = 32'h0000_1004; S_ARVALID = 1'b1; #1;
    checks++; if (S_RVALID !== 1'b1) begin errors++; $display("FAIL cold_hit: got %b expected 1", S_RVALID); end
    checks++; if (S_RDATA !== 32'hA1) begin errors++; $display("FAIL cold_data: got %h expected 000000a1", S_RDATA); end
    checks++; if ({w1_rvalid, w8_rvalid} !== 2'b11) begin errors++; $display("FAIL cold_hit_w1w8: got %b expected 11", {w1_rvalid, w8_rvalid}); end
    checks++; if (w1_rdata !== 32'hA1) begin errors++; $display("FAIL cold_data_w1: got %h expected 000000a1", w1_rdata); end
    checks++; if (w8_rdata !== 32'hA1) begin errors++; $display("FAIL cold_data_w8: got %h expected 000000a1", w8_rdata); end
    @(negedge CLK); S_ARVALID = 1'b0;
  endtask

  task automatic test_eviction();
    do_reset();
    fill_line(32'h000, 32'h100, "ev_l0");
    fill_line(32'h040, 32'h200, "ev_l1");
    fill_line(32'h080, 32'h300, "ev_l2");
    fill_line(32'h0C0, 32'h400, "ev_l3");
    probe_hit(32'h000, 32'h100, "ev_touch0");
    fill_line(32'h100, 32'h500, "ev_l4");
    probe_hit(32'h004, 32'h101, "ev_keep0");
    probe_hit(32'h108, 32'h502, "ev_new");
    probe_hit(32'h08C, 32'h303, "ev_keep2");
    probe_hit(32'h0C0, 32'h400, "ev_keep3");
    fill_line(32'h040, 32'h600, "ev_evicted");
  endtask

  task automatic test_fill_error();
    do_reset();
    start_miss(32'h0000_1004, "err");
    accept_ar("err");
    serve(32'hC0, 2, 3, -1, 1'b1, "err");
    start_miss(32'h0000_1004, "err_retry");
    accept_ar("err_retry");
    serve(32'hE0, -1, 3, -1, 1'b0, "err_retry");
    probe_hit(32'h0000_1004, 32'hE1, "err_retry");
    start_miss(32'h0000_3000, "short");
    accept_ar("short");
    serve(32'hF0, -1, 1, -1, 1'b1, "short");
    fill_line(32'h0000_3000, 32'h70, "short_retry");
    probe_hit(32'h0000_300C, 32'h73, "short_retry");
  endtask

  task automatic test_flush_mid_fill();
    do_reset();
    fill_line(32'h0000_1000, 32'h10, "fl_pre");
    probe_hit(32'h0000_1000, 32'h10, "fl_pre");
    start_miss(32'h0000_2040, "fl");
    accept_ar("fl");
    serve(32'h20, -1, 3, 0, 1'b0, "fl");
    probe_miss(32'h0000_1000, "fl_old");
    probe_miss(32'h0000_2040, "fl_new");
  endtask

  task automatic test_addr_change();
    do_reset();
    start_miss(32'h0000_1004, "ac");
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK); S_RADDR = 32'h0000_2000; S_ARVALID = 1'b1; #1;
      checks++; if ({M_ARVALID, M_ARADDR} !== {1'b1, 32'h0000_1000}) begin errors++; $display("FAIL ac_hold%0d: arvalid,araddr got %b,%h expected 1,00001000", c, M_ARVALID, M_ARADDR); end
    end
    S_ARVALID = 1'b0;
    accept_ar("ac");
    serve(32'hB0, -1, 3, -1, 1'b0, "ac");
    probe_hit(32'h0000_1004, 32'hB1, "ac_orig");
    probe_miss(32'h0000_2000, "ac_other");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    start_miss(32'h0000_1004, "rst");
    accept_ar("rst");
    for (int b = 0; b < 2; b++) begin
      M_RVALID = 1'b1; M_RDATA = 32'h50 + 32'(b); M_RLAST = 1'b0;
      @(negedge CLK);
    end
    M_RDATA = 32'h52; RES = 1'b1; #1;
    checks++; if ({M_RREADY, M_ARVALID, S_BUSY} !== 3'b000) begin errors++; $display("FAIL rst_async: rready,arvalid,busy got %b expected 000", {M_RREADY, M_ARVALID, S_BUSY}); end
    checks++; if (M_ARADDR !== 32'h0) begin errors++; $display("FAIL rst_araddr: got %h expected 0", M_ARADDR); end
    @(negedge CLK); RES = 1'b0; M_RDATA = 32'h53; M_RLAST = 1'b1; #1;
    checks++; if ({M_RREADY, S_RERR} !== 2'b00) begin errors++; $display("FAIL rst_trailing: rready,rerr got %b expected 00", {M_RREADY, S_RERR}); end
    @(negedge CLK); M_RVALID = 1'b0; M_RLAST = 1'b0;
    fill_line(32'h0000_1004, 32'h60, "rst_after");
    probe_hit(32'h0000_1004, 32'h61, "rst_after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_eviction();
    test_fill_error();
    test_flush_mid_fill();
    test_addr_change();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
